// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// controller states, digit width and a digit-count sanity check.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD3  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned DIGIT_W = 4;

  // True when d decimal digits can hold every w-bit binary value.
  function automatic bit digits_ok(input int unsigned w, input int unsigned d);
    longint unsigned max_bin;
    longint unsigned cap;
    max_bin = (64'd1 << w) - 64'd1;
    cap     = 64'd1;
    for (int unsigned i = 0; i < d; i++) begin
      cap = cap * 64'd10;
    end
    return cap > max_bin;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Single-digit shift-and-add-3 corrector: digits of 5 or more get +3.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = (d >= 4'd5) ? d + 4'd3 : d;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), init/done handshake,
// one ADD3/SHIFT pair per input bit, done held for DONE_HOLD cycles.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned W         = 16,
  parameter int unsigned D         = 5,
  parameter int unsigned DONE_HOLD = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic [W-1:0]         bin,
  output logic [DIGIT_W*D-1:0] bcd,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned BCD_W  = DIGIT_W * D;
  localparam int unsigned SR_W   = BCD_W + W;
  localparam int unsigned CNT_W  = $clog2(W + 1);
  localparam int unsigned HOLD_W = $clog2(DONE_HOLD + 1);

  if (!digits_ok(W, D) || DONE_HOLD < 1) begin : g_bad_params
    $error("bin2bcd_seq: D too small for W, or DONE_HOLD < 1");
  end

  state_t             state, state_n;
  logic [SR_W-1:0]    sr, sr_n, sr_fix;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [HOLD_W-1:0]  hold, hold_n;
  logic [BCD_W-1:0]   bcd_n;

  // Digit field sits above the binary field; correctors work without inter-digit carry.
  for (genvar g = 0; g < D; g++) begin : g_digit
    bcd_add3 u_add3 (
      .d(sr[W + DIGIT_W*g +: DIGIT_W]),
      .q(sr_fix[W + DIGIT_W*g +: DIGIT_W])
    );
  end
  assign sr_fix[W-1:0] = sr[W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      hold  <= '0;
      bcd   <= '0;
    end else begin
      state <= state_n;
      sr    <= sr_n;
      cnt   <= cnt_n;
      hold  <= hold_n;
      bcd   <= bcd_n;
    end
  end

  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    hold_n  = hold;
    bcd_n   = bcd;
    case (state)
      IDLE: begin
        if (init) begin
          sr_n    = SR_W'(bin);
          cnt_n   = CNT_W'(W);
          state_n = ADD3;
        end
      end
      ADD3: begin
        sr_n    = sr_fix;
        state_n = SHIFT;
      end
      SHIFT: begin
        sr_n  = {sr[SR_W-2:0], 1'b0};
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          bcd_n   = sr_n[SR_W-1 -: BCD_W];
          hold_n  = '0;
          state_n = DONE;
        end else begin
          state_n = ADD3;
        end
      end
      DONE: begin
        hold_n = hold + HOLD_W'(1);
        if (hold == HOLD_W'(DONE_HOLD - 1)) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == ADD3) || (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq against a decimal-arithmetic reference.
module tb_bin2bcd_seq;

  localparam int unsigned W    = 16;
  localparam int unsigned D    = 5;
  localparam int unsigned HOLD = 32;
  localparam int          LAT  = 2 * W;

  logic          clk;
  logic          rst;
  logic          init;
  logic [W-1:0]  bin;
  logic [4*D-1:0] bcd;
  logic          busy;
  logic          done;

  int vectors     = 0;
  int miscompares = 0;

  bin2bcd_seq #(.W(W), .D(D), .DONE_HOLD(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .init(init),
    .bin (bin),
    .bcd (bcd),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    x = v;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Starts one conversion from IDLE and waits (bounded) for done.
  task automatic convert(input logic [15:0] v, output int lat, output logic [19:0] res,
                         output bit stable, output bit busy_ok);
    logic [19:0] prev;
    @(negedge clk);
    init = 1'b1;
    bin  = v;
    prev = bcd;
    @(posedge clk); #1;
    init = 1'b0;
    bin  = 16'($urandom);
    lat = 0; stable = 1'b1; busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 200) begin
      if (bcd !== prev) stable = 1'b0;
      if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    res = bcd;
  endtask

  task automatic hold_len(output int n);
    n = 0;
    while (done === 1'b1 && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; init = 1'b0; bin = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bcd !== 20'h0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: bcd=%h busy=%b done=%b, want 00000/0/0", bcd, busy, done);
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (bcd !== 20'h0 || busy !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle c%0d: bcd=%h busy=%b done=%b, want 00000/0/0", i, bcd, busy, done);
      end
    end
  endtask

  task automatic test_basic();
    logic [15:0] vals [3];
    int lat, n;
    logic [19:0] res;
    bit st, bok;
    vals[0] = 16'd0; vals[1] = 16'd255; vals[2] = 16'd65535;
    for (int i = 0; i < 3; i++) begin
      convert(vals[i], lat, res, st, bok);
      vectors++;
      if (lat !== LAT) begin
        miscompares++;
        $display("FAIL basic_latency %0d: got %0d want %0d", vals[i], lat, LAT);
      end
      vectors++;
      if (res !== to_bcd(vals[i])) begin
        miscompares++;
        $display("FAIL basic_value %0d: got %h want %h", vals[i], res, to_bcd(vals[i]));
      end
      vectors++;
      if (bok !== 1'b1 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_busy %0d: busy_ok=%b busy_at_done=%b want 1/0", vals[i], bok, busy);
      end
      hold_len(n);
      vectors++;
      if (n !== HOLD) begin
        miscompares++;
        $display("FAIL basic_done_hold %0d: got %0d want %0d", vals[i], n, HOLD);
      end
    end
  endtask

  task automatic test_sqrt_chain();
    int unsigned r;
    int lat, n;
    logic [19:0] res;
    bit st, bok;
    r = 0;
    while ((r + 1) * (r + 1) <= 1000000) r++;
    convert(16'(r), lat, res, st, bok);
    vectors++;
    if (res !== 20'h01000) begin
      miscompares++;
      $display("FAIL sqrt_chain_value: got %h want %h", res, 20'h01000);
    end
    vectors++;
    if (st !== 1'b1) begin
      miscompares++;
      $display("FAIL sqrt_chain_bcd_hold: stable=%b want 1", st);
    end
    hold_len(n);
  endtask

  task automatic test_random();
    logic [15:0] v;
    int lat, n;
    logic [19:0] res;
    bit st, bok;
    for (int i = 0; i < 6; i++) begin
      v = 16'($urandom);
      convert(v, lat, res, st, bok);
      vectors++;
      if (lat !== LAT || res !== to_bcd(v) || st !== 1'b1 || bok !== 1'b1) begin
        miscompares++;
        $display("FAIL random %0d: lat=%0d bcd=%h stable=%b busy_ok=%b want %0d/%h/1/1",
                 v, lat, res, st, bok, LAT, to_bcd(v));
      end
      hold_len(n);
      vectors++;
      if (n !== HOLD) begin
        miscompares++;
        $display("FAIL random_done_hold %0d: got %0d want %0d", v, n, HOLD);
      end
    end
  endtask

  task automatic test_ignored_init();
    logic [15:0] a;
    int ndone;
    a = 16'($urandom_range(10, 65535));
    @(negedge clk); init = 1'b1; bin = a;
    @(posedge clk); #1;
    ndone = 0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      init = (c == 5 || c == 40);
      bin  = init ? 16'd9 : 16'($urandom);
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
      if (c == LAT) begin
        vectors++;
        if (done !== 1'b1 || bcd !== to_bcd(a)) begin
          miscompares++;
          $display("FAIL ignored_init_first: done=%b bcd=%h want 1/%h", done, bcd, to_bcd(a));
        end
      end
      if (c >= 65) begin
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== to_bcd(a)) begin
          miscompares++;
          $display("FAIL ignored_init_idle c%0d: busy=%b done=%b bcd=%h want 0/0/%h",
                   c, busy, done, bcd, to_bcd(a));
        end
      end
    end
    init = 1'b0;
    vectors++;
    if (ndone !== HOLD) begin
      miscompares++;
      $display("FAIL ignored_init_done_count: got %0d want %0d", ndone, HOLD);
    end
  endtask

  task automatic test_mid_reset();
    int lat, n;
    logic [19:0] res;
    bit st, bok;
    @(negedge clk); init = 1'b1; bin = 16'd12345;
    @(posedge clk); #1;
    init = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bcd !== 20'h0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_async: bcd=%h busy=%b done=%b want 00000/0/0", bcd, busy, done);
    end
    @(negedge clk); rst = 1'b0;
    convert(16'd12345, lat, res, st, bok);
    vectors++;
    if (res !== 20'h12345 || lat !== LAT || st !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_rerun: bcd=%h lat=%0d stable=%b want 12345/%0d/1", res, lat, st, LAT);
    end
    hold_len(n);
  endtask

  task automatic test_held_init();
    int rises[$];
    bit pb, pd;
    pb = 1'b0; pd = 1'b0;
    @(negedge clk); init = 1'b1; bin = 16'd4321;
    for (int n = 0; n < 210; n++) begin
      @(posedge clk); #1;
      vectors++;
      if (busy === 1'b1 && done === 1'b1) begin
        miscompares++;
        $display("FAIL held_overlap n%0d: busy=%b done=%b want not both 1", n, busy, done);
      end
      if (busy === 1'b1 && !pb) rises.push_back(n);
      if (done === 1'b1 && !pd) begin
        vectors++;
        if (bcd !== 20'h04321) begin
          miscompares++;
          $display("FAIL held_value n%0d: got %h want %h", n, bcd, 20'h04321);
        end
      end
      pb = (busy === 1'b1);
      pd = (done === 1'b1);
    end
    init = 1'b0;
    vectors++;
    if (rises.size() < 3) begin
      miscompares++;
      $display("FAIL held_starts: got %0d want >= 3", rises.size());
    end
    for (int i = 1; i < rises.size(); i++) begin
      vectors++;
      if (rises[i] - rises[i-1] !== LAT + HOLD + 1) begin
        miscompares++;
        $display("FAIL held_spacing %0d: got %0d want %0d", i, rises[i] - rises[i-1], LAT + HOLD + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sqrt_chain();
    test_random();
    test_ignored_init();
    test_mid_reset();
    test_held_init();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
